nios2_system_button_pio: RTL and testbench
==========================================

// Module: nios2_system_button_pio
// PURPOSE
//  Avalon-MM slave input PIO: inbound counterpart of the LED output PIO on the nios2_system bus.
//  Synchronises WIDTH external inputs (push-buttons/switches) and detects edges into a sticky
//  edge-capture register; raises a level IRQ to the Nios II when any captured, unmasked bit is set.
//  Zero-wait-state reads; readdata is combinational from address.
// PARAMETERS
//  WIDTH        4  number of input bits (1..32)
//  EDGE_TYPE    1  capture edge: 0=rising, 1=falling, 2=any
//  SYNC_STAGES  2  synchroniser depth on in_port (2..4)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      register word offset
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe (qualified by chipselect)
//  writedata   in   32     write data; bits above WIDTH ignored
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     read data, zero-extended above WIDTH
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  Reset: sync chain, prev-sample, irq_mask, edge_capture, prime counter = 0; readdata=0; irq=0.
//  Register map (read: combinational, every cycle; write: chipselect && !write_n, at clk edge):
//   0 DATA     RO  synchronised in_port; writes ignored
//   1 DIR      RO  reads 0; writes ignored
//   2 IRQMASK  RW  bit n=1 enables edge_capture[n] onto irq
//   3 EDGECAP  R/W1C  sticky edge flags; writing 1 to bit n clears it, 0 leaves it
//  Synchroniser: in_port change set up before edge 1 appears in DATA after edge SYNC_STAGES.
//  Edge detect: prev <= sync each clock; rise = sync & ~prev, fall = ~sync & prev, any = rise|fall.
//   Detected edge sets edge_capture bit at the next clock (edge SYNC_STAGES+1).
//  irq = |(edge_capture & irq_mask), combinational from registers: rises the cycle the capture
//   bit sets, or the cycle after IRQMASK write unmasking an already-set bit. No extra latency.
//  Prime counter: after reset release, edge detection suppressed until SYNC_STAGES+1 clocks
//   elapsed, so inputs held high/low through reset never produce spurious captures.
//  Simultaneous W1C clear and new edge on same bit in same cycle: set wins (bit stays 1).
//  Clear of bit n does not affect other bits; re-capture only on a new edge after clear.
//  Pulses shorter than one clock may be missed; no debounce (software responsibility).
//  Reset asserted mid-operation: all state cleared immediately (async), irq drops same instant.
//  Address 0..3 only; unused bits of writedata and readdata[31:WIDTH] ignored / driven 0.
// STRUCTURE
//  Shared package nios2_system_pio_pkg: register offsets ADDR_DATA=0, ADDR_DIR=1,
//   ADDR_IRQMASK=2, ADDR_EDGECAP=3; edge encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
//  Sub-module nios2_system_pio_sync: per-bit N-stage flop synchroniser (WIDTH, SYNC_STAGES),
//   async reset to 0. Edge detect, capture, mask, prime counter and read mux stay top-level.
// TESTING
//  T1 reset/idle: hold reset_n=0 with in_port=4'hF, release -> DATA reads 4'hF after 2 clks,
//     EDGECAP reads 0 and irq=0 for all time (prime suppression, EDGE_TYPE=1 and 0).
//  T2 falling capture: EDGE_TYPE=1, in_port 4'hF->4'hE, IRQMASK=4'h1 -> EDGECAP=4'h1 at edge 3,
//     irq=1 same cycle; write EDGECAP=4'h1 -> EDGECAP=0, irq=0 next cycle.
//  T3 masking: capture bit2 with IRQMASK=0 -> irq stays 0, EDGECAP=4'h4; write IRQMASK=4'h4
//     -> irq=1 cycle after write; write EDGECAP=4'h2 -> bit2 remains, irq stays 1.
//  T4 clear/set collision: W1C of bit0 in same cycle a new edge on bit0 is captured
//     -> EDGECAP bit0 reads 1, irq stays 1.
//  T5 register map: write 32'hFFFF_FFFF to addr 0 and 1 -> DATA unchanged, DIR reads 0;
//     IRQMASK write 32'hFFFF_FFFF reads back 32'h0000_000F.
//  T6 async reset mid-IRQ: irq=1, pulse reset_n low between clocks -> irq, IRQMASK, EDGECAP = 0
//     immediately; no capture for SYNC_STAGES+1 clocks after release (EDGE_TYPE=2 toggling).

Source files
------------

// File: rtl/nios2_system_pio_pkg.sv
// Shared definitions for the nios2_system PIO slaves: register offsets,
// edge-type encodings and the edge-select helper.
package nios2_system_pio_pkg;

  // Register word offsets on the Avalon-MM slave.
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  // Capture-edge encodings for the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Returns per-bit edge flags between the previous and current sample.
  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/nios2_system_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO, including its interrupt line.
interface nios2_system_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );
endinterface

// File: rtl/nios2_system_pio_sync.sv
// Per-bit multi-flop synchroniser bringing asynchronous inputs into clk.
module nios2_system_pio_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [SYNC_STAGES-1:0] chain_reg;

    // Shift the raw input through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        chain_reg <= '0;
      end else begin
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], din[gi]};
      end
    end

    assign dout[gi] = chain_reg[SYNC_STAGES-1];
  end

endmodule

// File: rtl/nios2_system_button_pio.sv
// Input PIO: synchronised button/switch inputs, sticky edge capture with
// write-one-to-clear, per-bit interrupt mask and a level IRQ.
module nios2_system_button_pio
  import nios2_system_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALL,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios2_system_button_pio_if.slave  bus,
  input  logic [WIDTH-1:0]          in_port
);

  // Edge detection stays disabled until the synchroniser and the previous
  // sample both hold real input values, otherwise inputs held through reset
  // would look like edges coming out of the all-zero reset state.
  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [2:0]       prime_cnt_reg;
  logic [2:0]       prime_cnt_next;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] edge_hit;
  logic             wr_en;
  logic             primed;

  nios2_system_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync_data)
  );

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign wr_bits  = WIDTH'(bus.writedata);
  assign primed   = (prime_cnt_reg == PRIME_DONE);
  assign edge_hit = WIDTH'(edge_select(EDGE_TYPE, 32'(sync_data), 32'(prev_reg)));

  // Next-state for mask, capture flags and prime counter; a new edge
  // overrides a same-cycle write-one-to-clear on the same bit.
  always_comb begin
    irq_mask_next     = irq_mask_reg;
    edge_capture_next = edge_capture_reg;
    prime_cnt_next    = prime_cnt_reg;
    if (!primed) begin
      prime_cnt_next = prime_cnt_reg + 3'd1;
    end
    if (wr_en && (bus.address == ADDR_IRQMASK)) begin
      irq_mask_next = wr_bits;
    end
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      edge_capture_next = edge_capture_reg & ~wr_bits;
    end
    if (primed) begin
      edge_capture_next = edge_capture_next | edge_hit;
    end
  end

  // State registers, cleared asynchronously so irq drops the moment reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg         <= '0;
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
      prime_cnt_reg    <= '0;
    end else begin
      prev_reg         <= sync_data;
      irq_mask_reg     <= irq_mask_next;
      edge_capture_reg <= edge_capture_next;
      prime_cnt_reg    <= prime_cnt_next;
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(sync_data);
      ADDR_DIR:     bus.readdata = '0;
      ADDR_IRQMASK: bus.readdata = 32'(irq_mask_reg);
      ADDR_EDGECAP: bus.readdata = 32'(edge_capture_reg);
      default:      bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_nios2_system_button_pio.sv
// Directed bench for the button PIO: falling-edge instance for the main
// register/IRQ behaviour, rising and any-edge instances for reset priming.
module tb_nios2_system_button_pio;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_fall;
  logic [3:0] in_rise;
  logic [3:0] in_any;
  int         check_count;
  int         pass_count;

  nios2_system_button_pio_if bus_fall();
  nios2_system_button_pio_if bus_rise();
  nios2_system_button_pio_if bus_any();

  nios2_system_button_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
    .clk(clk), .reset_n(reset_n), .bus(bus_fall), .in_port(in_fall)
  );
  nios2_system_button_pio #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus_rise), .in_port(in_rise)
  );
  nios2_system_button_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .bus(bus_any), .in_port(in_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_fall(input logic [1:0] a, input logic [31:0] d);
    bus_fall.address    = a;
    bus_fall.writedata  = d;
    bus_fall.chipselect = 1'b1;
    bus_fall.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_fall.chipselect = 1'b0;
    bus_fall.write_n    = 1'b1;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic read_fall(input logic [1:0] a, output logic [31:0] d);
    bus_fall.address    = a;
    bus_fall.chipselect = 1'b1;
    bus_fall.write_n    = 1'b1;
    #1;
    d = bus_fall.readdata;
    $display("rd addr=%0d data=%h irq=%0b", a, d, bus_fall.irq);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    #1;
    read_fall(2'd0, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL reset_data: got %h expected %h", rd, 32'h0); else pass_count++;
    read_fall(2'd2, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL reset_irqmask: got %h expected %h", rd, 32'h0); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus_fall.irq); else pass_count++;
    clk_n(3);
    reset_n = 1'b1;
    clk_n(1);
    read_fall(2'd0, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t1_data_edge1: got %h expected %h", rd, 32'h0); else pass_count++;
    clk_n(1);
    read_fall(2'd0, rd);
    check_count++;
    if (rd !== 32'hF) $display("FAIL t1_data_edge2: got %h expected %h", rd, 32'hF); else pass_count++;
    for (int k = 3; k <= 8; k++) begin
      clk_n(1);
      read_fall(2'd3, rd);
      check_count++;
      if (rd !== 32'h0) $display("FAIL t1_fall_edgecap edge%0d: got %h expected %h", k, rd, 32'h0); else pass_count++;
      check_count++;
      if (bus_rise.readdata !== 32'h0) $display("FAIL t1_rise_edgecap edge%0d: got %h expected %h", k, bus_rise.readdata, 32'h0); else pass_count++;
      check_count++;
      if (bus_any.readdata !== 32'h0) $display("FAIL t1_any_edgecap edge%0d: got %h expected %h", k, bus_any.readdata, 32'h0); else pass_count++;
      check_count++;
      if ((bus_fall.irq | bus_rise.irq | bus_any.irq) !== 1'b0) $display("FAIL t1_irq edge%0d: got %b expected 0", k, bus_fall.irq | bus_rise.irq | bus_any.irq); else pass_count++;
    end
  endtask

  task automatic test_fall_capture();
    logic [31:0] rd;
    write_fall(2'd2, 32'h1);
    in_fall = 4'hE;
    for (int k = 1; k <= 2; k++) begin
      clk_n(1);
      read_fall(2'd3, rd);
      check_count++;
      if (rd !== 32'h0) $display("FAIL t2_edgecap_early edge%0d: got %h expected %h", k, rd, 32'h0); else pass_count++;
      check_count++;
      if (bus_fall.irq !== 1'b0) $display("FAIL t2_irq_early edge%0d: got %b expected 0", k, bus_fall.irq); else pass_count++;
    end
    clk_n(1);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h1) $display("FAIL t2_edgecap_edge3: got %h expected %h", rd, 32'h1); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t2_irq_edge3: got %b expected 1", bus_fall.irq); else pass_count++;
    write_fall(2'd3, 32'h1);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t2_edgecap_cleared: got %h expected %h", rd, 32'h0); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b0) $display("FAIL t2_irq_cleared: got %b expected 0", bus_fall.irq); else pass_count++;
  endtask

  task automatic test_masking();
    logic [31:0] rd;
    write_fall(2'd2, 32'h0);
    in_fall = 4'hA;
    clk_n(2);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t3_edgecap_edge2: got %h expected %h", rd, 32'h0); else pass_count++;
    clk_n(1);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL t3_edgecap_masked: got %h expected %h", rd, 32'h4); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b0) $display("FAIL t3_irq_masked: got %b expected 0", bus_fall.irq); else pass_count++;
    write_fall(2'd2, 32'h4);
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t3_irq_unmasked: got %b expected 1", bus_fall.irq); else pass_count++;
    write_fall(2'd3, 32'h2);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL t3_edgecap_other_clear: got %h expected %h", rd, 32'h4); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t3_irq_other_clear: got %b expected 1", bus_fall.irq); else pass_count++;
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    write_fall(2'd2, 32'h1);
    in_fall = 4'hB;
    clk_n(4);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL t4_rise_ignored: got %h expected %h", rd, 32'h4); else pass_count++;
    in_fall = 4'hA;
    clk_n(3);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h5) $display("FAIL t4_bit0_captured: got %h expected %h", rd, 32'h5); else pass_count++;
    in_fall = 4'hB;
    clk_n(4);
    in_fall = 4'hA;
    clk_n(2);
    write_fall(2'd3, 32'h1);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h5) $display("FAIL t4_set_wins: got %h expected %h", rd, 32'h5); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t4_irq_set_wins: got %b expected 1", bus_fall.irq); else pass_count++;
    write_fall(2'd3, 32'h1);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL t4_plain_clear: got %h expected %h", rd, 32'h4); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b0) $display("FAIL t4_irq_plain_clear: got %b expected 0", bus_fall.irq); else pass_count++;
  endtask

  task automatic test_register_map();
    logic [31:0] rd;
    write_fall(2'd0, 32'hFFFF_FFFF);
    write_fall(2'd1, 32'hFFFF_FFFF);
    read_fall(2'd0, rd);
    check_count++;
    if (rd !== 32'h0000_000A) $display("FAIL t5_data_ro: got %h expected %h", rd, 32'h0000_000A); else pass_count++;
    read_fall(2'd1, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t5_dir_zero: got %h expected %h", rd, 32'h0); else pass_count++;
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL t5_edgecap_untouched: got %h expected %h", rd, 32'h4); else pass_count++;
    write_fall(2'd2, 32'hFFFF_FFFF);
    read_fall(2'd2, rd);
    check_count++;
    if (rd !== 32'h0000_000F) $display("FAIL t5_irqmask_width: got %h expected %h", rd, 32'h0000_000F); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t5_irq_all_mask: got %b expected 1", bus_fall.irq); else pass_count++;
    bus_fall.address    = 2'd2;
    bus_fall.writedata  = 32'h0;
    bus_fall.chipselect = 1'b0;
    bus_fall.write_n    = 1'b0;
    clk_n(1);
    bus_fall.write_n    = 1'b1;
    read_fall(2'd2, rd);
    check_count++;
    if (rd !== 32'h0000_000F) $display("FAIL t5_unselected_write: got %h expected %h", rd, 32'h0000_000F); else pass_count++;
    write_fall(2'd3, 32'hF);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t5_clear_all: got %h expected %h", rd, 32'h0); else pass_count++;
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    in_fall = 4'h8;
    clk_n(3);
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL t6_pre_edgecap: got %h expected %h", rd, 32'h2); else pass_count++;
    check_count++;
    if (bus_fall.irq !== 1'b1) $display("FAIL t6_pre_irq: got %b expected 1", bus_fall.irq); else pass_count++;
    reset_n = 1'b0;
    #1;
    check_count++;
    if (bus_fall.irq !== 1'b0) $display("FAIL t6_irq_async: got %b expected 0", bus_fall.irq); else pass_count++;
    read_fall(2'd2, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t6_irqmask_async: got %h expected %h", rd, 32'h0); else pass_count++;
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t6_edgecap_async: got %h expected %h", rd, 32'h0); else pass_count++;
    reset_n = 1'b1;
    // in_any is 4'hF while reset releases, then toggles after every edge.
    for (int k = 1; k <= 4; k++) begin
      clk_n(1);
      check_count++;
      if (bus_any.readdata !== ((k < 4) ? 32'h0 : 32'hF))
        $display("FAIL t6_any_prime edge%0d: got %h expected %h", k, bus_any.readdata, (k < 4) ? 32'h0 : 32'hF);
      else
        pass_count++;
      in_any = (k % 2 == 1) ? 4'h0 : 4'hF;
    end
    read_fall(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL t6_fall_no_capture: got %h expected %h", rd, 32'h0); else pass_count++;
    read_fall(2'd0, rd);
    check_count++;
    if (rd !== 32'h8) $display("FAIL t6_data_after_reset: got %h expected %h", rd, 32'h8); else pass_count++;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset_n     = 1'b1;
    in_fall     = 4'hF;
    in_rise     = 4'hF;
    in_any      = 4'hF;
    bus_fall.address    = 2'd0;
    bus_fall.chipselect = 1'b0;
    bus_fall.write_n    = 1'b1;
    bus_fall.writedata  = 32'h0;
    bus_rise.address    = 2'd3;
    bus_rise.chipselect = 1'b0;
    bus_rise.write_n    = 1'b1;
    bus_rise.writedata  = 32'h0;
    bus_any.address     = 2'd3;
    bus_any.chipselect  = 1'b0;
    bus_any.write_n     = 1'b1;
    bus_any.writedata   = 32'h0;
    #1;
    test_reset();
    test_fall_capture();
    test_masking();
    test_collision();
    test_register_map();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
